// File: rtl/ibuf_fill_controller.sv
// ibuf_fill_controller: runs one IBUF fill transaction. It accepts num_beats
// DDR beats on a valid/ready input, holds each beat in a register and writes
// it into the bank array one row per cycle. The write enable, row address and
// row data are common to all banks.
// The write-side outputs, busy and done come straight from flops. Their next
// values are decoded from the FSM's next state, so each one is exactly one
// cycle ahead.
module ibuf_fill_controller #(
  parameter int DDR_BANDWIDTH = 512,
  parameter int NUM_BANKS     = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int RATIO         = DDR_BANDWIDTH / (NUM_BANKS * DATA_WIDTH),
  parameter int ADDR_W        = 10,
  parameter int BEAT_CNT_W    = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [ADDR_W-1:0]               base_addr,
  input  logic [BEAT_CNT_W-1:0]           num_beats,
  output logic                            busy,
  output logic                            done,
  input  logic [DDR_BANDWIDTH-1:0]        data_in,
  input  logic                            data_in_valid,
  output logic                            data_in_ready,
  output logic                            ibuf_wr_en,
  output logic [ADDR_W-1:0]               ibuf_wr_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] ibuf_wr_data
);

  localparam int ROW_BITS = NUM_BANKS * DATA_WIDTH;
  localparam int ROW_W    = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(RATIO - 1);
  localparam logic [ROW_W-1:0]      ROW_ONE   = ROW_W'(1);
  localparam logic [ADDR_W-1:0]     ADDR_ONE  = ADDR_W'(1);
  localparam logic [BEAT_CNT_W-1:0] BEAT_ONE  = BEAT_CNT_W'(1);
  localparam logic [BEAT_CNT_W-1:0] BEAT_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [DDR_BANDWIDTH-1:0] beat_q, beat_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [BEAT_CNT_W-1:0]    beats_left_q, beats_left_d;

  logic                     wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic [ROW_BITS-1:0]      wr_data_q, wr_data_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic                     more_beats;

  // The row view of the next beat register. It feeds the wr_data flop.
  logic [ROW_BITS-1:0] next_rows [RATIO];

  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_rows
      assign next_rows[gi] = beat_d[gi*ROW_BITS +: ROW_BITS];
    end
  endgenerate

  assign more_beats = (beats_left_q != BEAT_ZERO);

  // Next-state, counter and beat-register logic, plus the ready handshake.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    row_d         = row_q;
    addr_d        = addr_q;
    beats_left_d  = beats_left_q;
    data_in_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d       = base_addr;
          beats_left_d = num_beats;
          state_d      = (num_beats == BEAT_ZERO) ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        data_in_ready = 1'b1;
        if (data_in_valid) begin
          beat_d       = data_in;
          row_d        = '0;
          beats_left_d = beats_left_q - BEAT_ONE;
          state_d      = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A row is written this cycle at addr_q, so the next write uses the
        // next address.
        addr_d = addr_q + ADDR_ONE;
        if (row_q != LAST_ROW) begin
          row_d = row_q + ROW_ONE;
        end else begin
          // On the last row, accept the next beat so writes continue with no gap.
          data_in_ready = more_beats;
          if (more_beats && data_in_valid) begin
            beat_d       = data_in;
            row_d        = '0;
            beats_left_d = beats_left_q - BEAT_ONE;
          end else if (more_beats) begin
            state_d = ST_FILL;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output flops are loaded one cycle early from the decoded next state.
  always_comb begin
    wr_en_d   = (state_d == ST_DRAIN);
    wr_addr_d = addr_d;
    wr_data_d = wr_en_d ? next_rows[row_d] : '0;
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  // State, counters, beat register and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      beats_left_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      row_q        <= row_d;
      addr_q       <= addr_d;
      beats_left_q <= beats_left_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign ibuf_wr_en   = wr_en_q;
  assign ibuf_wr_addr = wr_addr_q;
  assign ibuf_wr_data = wr_data_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_ibuf_fill_controller.sv
// Bench for ibuf_fill_controller. The reference model works per transfer.
// Each accepted beat expands into RATIO expected writes: consecutive addresses
// modulo 2^ADDR_W, row r of the beat, and the cycle it must appear on. A
// monitor compares every observed write and done pulse against that list.
module tb_ibuf_fill_controller;

  localparam int DDR_BW = 512;
  localparam int NB     = 8;
  localparam int DW     = 8;
  localparam int RATIO  = 8;
  localparam int AW     = 10;
  localparam int BW     = 16;
  localparam int RB     = NB * DW;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic [BW-1:0]     num_beats = '0;
  logic              busy, done;
  logic [DDR_BW-1:0] data_in = '0;
  logic              data_in_valid = 1'b0;
  logic              data_in_ready;
  logic              ibuf_wr_en;
  logic [AW-1:0]     ibuf_wr_addr;
  logic [RB-1:0]     ibuf_wr_data;

  ibuf_fill_controller #(
    .DDR_BANDWIDTH(DDR_BW), .NUM_BANKS(NB), .DATA_WIDTH(DW),
    .ADDR_W(AW), .BEAT_CNT_W(BW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_beats(num_beats), .busy(busy), .done(done), .data_in(data_in),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .ibuf_wr_en(ibuf_wr_en), .ibuf_wr_addr(ibuf_wr_addr),
    .ibuf_wr_data(ibuf_wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [RB-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  logic [AW-1:0] m_addr = '0;
  int            m_beats_left = 0;
  int            exp_done_cyc = -100;
  bit            zero_len = 1'b0;
  int            start_cyc = 0;
  int            xfer_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int            busy_cyc = 0, ready_cyc = 0;
  int            run = 0, max_run = 0, last_wr_cyc = -10;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (busy) busy_cyc++;
      if (data_in_ready) ready_cyc++;
      if (data_in_valid && data_in_ready) begin
        xfer_cnt++;
        for (int r = 0; r < RATIO; r++) begin
          mon_e.cyc  = cyc + 1 + r;
          mon_e.addr = m_addr;
          mon_e.data = data_in[r*RB +: RB];
          exp_q.push_back(mon_e);
          m_addr++;
        end
        m_beats_left--;
        if (m_beats_left == 0) exp_done_cyc = cyc + RATIO + 1;
      end
      if (ibuf_wr_en) begin
        wr_cnt++;
        run = (cyc == last_wr_cyc + 1) ? run + 1 : 1;
        if (run > max_run) max_run = run;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", 64'(1), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 64'(ibuf_wr_addr), 64'(mon_e.addr));
          chk("wr_data", 64'(ibuf_wr_data), 64'(mon_e.data));
          chk("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end
      if (done) begin
        done_cnt++;
        if (zero_len)
          chk("zero_done_lat", 64'((cyc > start_cyc) && (cyc - start_cyc <= 2)), 64'(1));
        else
          chk("done_cycle", 64'(cyc), 64'(exp_done_cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    exp_q.delete();
    xfer_cnt = 0; wr_cnt = 0; done_cnt = 0; busy_cyc = 0; ready_cyc = 0;
    run = 0; max_run = 0; last_wr_cyc = -10;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input int n);
    clear_stats();
    m_addr       = b;
    m_beats_left = n;
    zero_len     = (n == 0);
    exp_done_cyc = -100;
    start_cyc    = cyc;
    base_addr    = b;
    num_beats    = BW'(n);
    start        = 1'b1;
    tick();
    start        = 1'b0;
    base_addr    = AW'($urandom);
    num_beats    = BW'($urandom);
  endtask

  task automatic send_beat(input logic [DDR_BW-1:0] d);
    bit got = 1'b0;
    data_in       = d;
    data_in_valid = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = data_in_ready;
      @(posedge clk);
      #1;
    end
    if (!got) chk("xfer_timeout", 64'(0), 64'(1));
  endtask

  function automatic logic [DDR_BW-1:0] rand_beat();
    logic [DDR_BW-1:0] v;
    for (int i = 0; i < DDR_BW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [DDR_BW-1:0] ramp_beat();
    logic [DDR_BW-1:0] v;
    for (int k = 0; k < DDR_BW / DW; k++) v[k*DW +: DW] = DW'(k);
    return v;
  endfunction

  task automatic wait_done(input int budget);
    int n0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == n0; i++) tick();
    chk("done_seen", 64'(done_cnt != n0), 64'(1));
  endtask

  task automatic finish_txn(input string name, input int exp_xfers);
    tick();
    chk({name, "_pending"}, 64'(exp_q.size()), 64'(0));
    chk({name, "_xfers"}, 64'(xfer_cnt), 64'(exp_xfers));
    chk({name, "_writes"}, 64'(wr_cnt), 64'(exp_xfers * RATIO));
    chk({name, "_dones"}, 64'(done_cnt), 64'(1));
    chk({name, "_idle"}, 64'(busy), 64'(0));
    $display("txn %s: xfers=%0d writes=%0d dones=%0d", name, xfer_cnt, wr_cnt, done_cnt);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_busy"}, 64'(busy), 64'(0));
    chk({name, "_done"}, 64'(done), 64'(0));
    chk({name, "_ready"}, 64'(data_in_ready), 64'(0));
    chk({name, "_wr_en"}, 64'(ibuf_wr_en), 64'(0));
    chk({name, "_wr_addr"}, 64'(ibuf_wr_addr), 64'(0));
    chk({name, "_wr_data"}, 64'(ibuf_wr_data), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] b;
    logic [AW-1:0] row3_addr;
    bit            found;

    // Reset state.
    #1;
    chk_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // Single beat with a ramp pattern: bank b of row r carries r*8+b.
    do_start(10'h010, 1);
    send_beat(ramp_beat());
    data_in_valid = 1'b0;
    wait_done(40);
    finish_txn("single", 1);

    // Three beats back to back with valid held high.
    b = AW'($urandom);
    do_start(b, 3);
    for (int j = 0; j < 3; j++) send_beat(rand_beat());
    data_in_valid = 1'b0;
    wait_done(60);
    finish_txn("b2b", 3);
    chk("b2b_run", 64'(max_run), 64'(3 * RATIO));

    // Valid bubble: the second beat arrives 5 cycles after the first drain ends.
    b = AW'($urandom);
    do_start(b, 2);
    send_beat(rand_beat());
    data_in_valid = 1'b0;
    data_in       = rand_beat();
    repeat (RATIO - 1 + 5) tick();
    chk("bubble_ready", 64'(data_in_ready), 64'(1));
    chk("bubble_wr_en", 64'(ibuf_wr_en), 64'(0));
    chk("bubble_busy", 64'(busy), 64'(1));
    send_beat(rand_beat());
    data_in_valid = 1'b0;
    wait_done(40);
    finish_txn("bubble", 2);

    // Zero-length transaction.
    do_start(AW'($urandom), 0);
    wait_done(10);
    finish_txn("zero", 0);
    chk("zero_busy_cycles", 64'(busy_cyc), 64'(1));
    chk("zero_ready_cycles", 64'(ready_cyc), 64'(0));

    // Address wrap, with a start pulse during DRAIN that must be ignored.
    do_start(10'h3FC, 1);
    send_beat(rand_beat());
    data_in_valid = 1'b0;
    tick();
    base_addr = 10'h100;
    num_beats = 16'd5;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    wait_done(40);
    finish_txn("wrap", 1);
    repeat (4) tick();
    chk("wrap_no_restart_busy", 64'(busy), 64'(0));
    chk("wrap_no_restart_wr", 64'(wr_cnt), 64'(RATIO));

    // Reset during row 3 of the first of two beats.
    b = AW'($urandom);
    row3_addr = b + AW'(3);
    do_start(b, 2);
    send_beat(rand_beat());
    data_in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = ibuf_wr_en && (ibuf_wr_addr == row3_addr);
    end
    chk("rst_row3_seen", 64'(found), 64'(1));
    #2 reset = 1'b1;
    #1;
    chk_outputs_zero("midrst");
    @(posedge clk);
    #1 reset = 1'b0;
    clear_stats();
    repeat (10) tick();
    chk("midrst_no_done", 64'(done_cnt), 64'(0));
    chk("midrst_no_wr", 64'(wr_cnt), 64'(0));
    chk("midrst_idle", 64'(busy), 64'(0));
    $display("txn midrst: writes_after_reset=%0d dones=%0d", wr_cnt, done_cnt);

    // A fresh single-beat transaction after the reset.
    do_start(10'h010, 1);
    send_beat(ramp_beat());
    data_in_valid = 1'b0;
    wait_done(40);
    finish_txn("post_rst", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
